// File: rtl/timer_arb_pkg.sv
// Shared types and default sizing for the timer arbiter.
// Contents: state_t (IDLE, LOAD, RUN, DONE), DEF_N_REQ, DEF_WIDTH.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_N_REQ = 2;
  localparam int unsigned DEF_WIDTH = 13;

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Ports:
//   req    - request vector
//   ptr    - index where the search starts
//   winner - one-hot of the chosen requester (0 when none)
//   index  - binary index of the chosen requester
//   any    - at least one request is set
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IDXW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDXW-1:0]  index,
  output logic             any
);

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    logic [IDXW-1:0] j;
    winner = '0;
    index  = '0;
    any    = 1'b0;
    j      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = IDXW'((32'(ptr) + i) % N_REQ);
      if (!any && req[j]) begin
        any       = 1'b1;
        index     = j;
        winner[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one down-counting phase timer between N_REQ requesters with
// round-robin grant, one-cycle done pulse to the owner, and a live count.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   tick        - count-enable strobe
//   req         - per-requester level request, held until done
//   load_value  - requester i load value in [i*WIDTH +: WIDTH]
//   grant       - one-hot timer owner (registered)
//   done        - one-cycle expiry pulse to owner (registered)
//   busy        - high whenever not idle (registered)
//   count       - current counter value (registered)
// Optional: define TIMER_ARB_ABORT_EN to let the owner abort by dropping req
// during LOAD or RUN (no done pulse, count cleared, rr pointer advanced).
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] load_value,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       count
);

  localparam int unsigned IDXW = $clog2(N_REQ);

  state_t          state;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] next_ptr;
  logic [WIDTH-1:0] owner_load;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_any;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  assign owner_load = load_value[32'(owner)*WIDTH +: WIDTH];
  assign next_ptr   = (owner == IDXW'(N_REQ - 1)) ? '0 : owner + IDXW'(1);

  // Arbitration FSM with counter; later assignments in a state override earlier ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      count  <= '0;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_onehot;
            owner <= pick_idx;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          count <= owner_load;
          state <= RUN;
`ifdef TIMER_ARB_ABORT_EN
          if (!req[owner]) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
            count  <= '0;
            rr_ptr <= next_ptr;
          end
`endif
        end
        RUN: begin
          // Expiry is checked every clock, so a zero load needs no tick.
          if (count == '0) begin
            done  <= grant;
            state <= DONE;
          end else if (tick) begin
            count <= count - WIDTH'(1);
          end
`ifdef TIMER_ARB_ABORT_EN
          if (!req[owner]) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
            count  <= '0;
            rr_ptr <= next_ptr;
          end
`endif
        end
        DONE: begin
          grant  <= '0;
          done   <= '0;
          busy   <= 1'b0;
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
